// File: rtl/axis_img_source.sv
// ---------------------------------------------------------------------------
// axis_img_source
//
// AXI4-Stream test-pattern image source. On a start request it emits one
// frame of IMG_W x IMG_H pixels. Each pixel value is its raster index
// (y*IMG_W + x) truncated to DATA_W bits. TUSER marks the first pixel of the
// frame and TLAST marks the last pixel of every line. Optional idle cycles
// can be inserted every GAP_EVERY transfers to exercise downstream
// consumers. The block also tracks consumer back-pressure: it keeps a
// consecutive stall counter and sets a sticky "blocked" flag once the
// counter reaches BLOCK_LIMIT.
//
// Parameters
//   DATA_W       pixel / TDATA width in bits
//   IMG_W        pixels per line
//   IMG_H        lines per frame
//   GAP_EVERY    transfers between inserted idle cycles (when gap_en=1)
//   BLOCK_LIMIT  consecutive stalled cycles before blocked is raised
//
// Ports
//   ap_clk         clock, all state changes on the rising edge
//   ap_rst_n       asynchronous active-low reset
//   start          frame request, only honoured while idle
//   gap_en         enables periodic idle-cycle insertion, sampled per transfer
//   img_in_TDATA   pixel data
//   img_in_TVALID  data valid
//   img_in_TREADY  consumer ready
//   img_in_TLAST   last pixel of a line
//   img_in_TUSER   first pixel of the frame
//   busy           high while a frame is in progress
//   done           one-cycle pulse after the final transfer
//   blocked        sticky flag, stall limit was reached during this frame
//   stall_cnt      current consecutive stall count (saturating)
// ---------------------------------------------------------------------------
module axis_img_source #(
    parameter int DATA_W      = 8,
    parameter int IMG_W       = 16,
    parameter int IMG_H       = 16,
    parameter int GAP_EVERY   = 4,
    parameter int BLOCK_LIMIT = 64
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              start,
    input  logic              gap_en,
    output logic [DATA_W-1:0] img_in_TDATA,
    output logic              img_in_TVALID,
    input  logic              img_in_TREADY,
    output logic              img_in_TLAST,
    output logic              img_in_TUSER,
    output logic              busy,
    output logic              done,
    output logic              blocked,
    output logic [15:0]       stall_cnt
);

    // Counter widths are kept at least one bit wide so degenerate
    // configurations (single pixel line, single line frame, gap every
    // transfer) still elaborate.
    localparam int X_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int Y_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int G_W = (GAP_EVERY > 1) ? $clog2(GAP_EVERY) : 1;

    localparam logic [X_W-1:0] X_LAST         = X_W'(IMG_W - 1);
    localparam logic [Y_W-1:0] Y_LAST         = Y_W'(IMG_H - 1);
    localparam logic [G_W-1:0] G_LAST         = G_W'(GAP_EVERY - 1);
    localparam logic [15:0]    STALL_MAX      = 16'hFFFF;
    localparam logic [15:0]    STALL_LIMIT    = 16'(BLOCK_LIMIT);
    localparam logic           FIRST_IS_LAST  = (IMG_W == 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t         state;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [G_W-1:0] xfer_cnt;

    logic           xfer;
    logic           x_end;
    logic           y_end;
    logic           gap_hit;
    logic [X_W-1:0] x_next;
    logic [Y_W-1:0] y_next;

    // A beat is accepted whenever valid and ready meet. The coordinate of
    // the beat currently presented is (x, y); x_next/y_next give the
    // coordinate of the beat that follows it in raster order.
    assign xfer    = img_in_TVALID & img_in_TREADY;
    assign x_end   = (x == X_LAST);
    assign y_end   = (y == Y_LAST);
    assign gap_hit = gap_en & (xfer_cnt == G_LAST);
    assign x_next  = x_end ? '0 : x + 1'b1;
    assign y_next  = x_end ? y + 1'b1 : y;

    // Frame sequencer with fully registered stream and status outputs.
    // TDATA is advanced by a running increment rather than recomputed as
    // y*IMG_W + x: consecutive raster indices differ by exactly one, and the
    // DATA_W-bit adder wraps naturally, which yields the truncated index
    // without a multiplier. The output registers are only updated on an
    // accepted beat, so they hold steady while the consumer stalls.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state         <= IDLE;
            x             <= '0;
            y             <= '0;
            xfer_cnt      <= '0;
            img_in_TDATA  <= '0;
            img_in_TVALID <= 1'b0;
            img_in_TLAST  <= 1'b0;
            img_in_TUSER  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            blocked       <= 1'b0;
            stall_cnt     <= '0;
        end else begin
            done <= 1'b0;

            // The flag rises one cycle after the counter reaches the limit
            // and stays up; only a new accepted start (below) clears it.
            if (stall_cnt >= STALL_LIMIT) begin
                blocked <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state         <= SEND;
                        x             <= '0;
                        y             <= '0;
                        xfer_cnt      <= '0;
                        stall_cnt     <= '0;
                        blocked       <= 1'b0;
                        busy          <= 1'b1;
                        img_in_TVALID <= 1'b1;
                        img_in_TDATA  <= '0;
                        img_in_TUSER  <= 1'b1;
                        img_in_TLAST  <= FIRST_IS_LAST;
                    end
                end

                SEND: begin
                    if (xfer) begin
                        stall_cnt <= '0;
                        // End of frame wins over a pending gap so the
                        // frame never finishes with a trailing idle cycle.
                        if (x_end && y_end) begin
                            state         <= DONE;
                            done          <= 1'b1;
                            img_in_TVALID <= 1'b0;
                            img_in_TDATA  <= '0;
                            img_in_TLAST  <= 1'b0;
                            img_in_TUSER  <= 1'b0;
                            x             <= '0;
                            y             <= '0;
                        end else begin
                            x            <= x_next;
                            y            <= y_next;
                            img_in_TDATA <= img_in_TDATA + 1'b1;
                            img_in_TLAST <= (x_next == X_LAST);
                            img_in_TUSER <= 1'b0;
                            // With gaps disabled the transfer counter is
                            // frozen so re-enabling gap_en resumes counting
                            // from where it stopped.
                            if (gap_en) begin
                                if (gap_hit) begin
                                    state         <= GAP;
                                    img_in_TVALID <= 1'b0;
                                    xfer_cnt      <= '0;
                                end else begin
                                    xfer_cnt <= xfer_cnt + 1'b1;
                                end
                            end
                        end
                    end else if (stall_cnt != STALL_MAX) begin
                        stall_cnt <= stall_cnt + 16'd1;
                    end
                end

                // Single idle beat; the next pixel is already staged in the
                // output registers and is presented again on return.
                GAP: begin
                    state         <= SEND;
                    img_in_TVALID <= 1'b1;
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state         <= IDLE;
                    busy          <= 1'b0;
                    img_in_TVALID <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_img_source.sv
// ---------------------------------------------------------------------------
// tb_axis_img_source
//
// Directed bench for axis_img_source. Two instances are used: a small 4x2
// image with GAP_EVERY=4 and BLOCK_LIMIT=8 for the frame, gap, stall,
// blocked and reset scenarios, and an 8x4 image with 4-bit pixels for the
// TDATA wrap-around case. Expected beats are queued when a frame is started
// and popped as the DUT transfers them; stall_cnt and blocked follow a small
// reference model advanced once per cycle.
// ---------------------------------------------------------------------------
module tb_axis_img_source;

    localparam int DATA_W      = 8;
    localparam int IMG_W       = 4;
    localparam int IMG_H       = 2;
    localparam int GAP_EVERY   = 4;
    localparam int BLOCK_LIMIT = 8;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
    } pix_t;

    logic              ap_clk        = 1'b0;
    logic              ap_rst_n      = 1'b1;
    logic              start         = 1'b0;
    logic              gap_en        = 1'b0;
    logic              img_in_TREADY = 1'b1;
    logic [DATA_W-1:0] img_in_TDATA;
    logic              img_in_TVALID;
    logic              img_in_TLAST;
    logic              img_in_TUSER;
    logic              busy;
    logic              done;
    logic              blocked;
    logic [15:0]       stall_cnt;

    logic              b_start = 1'b0;
    logic              b_gap   = 1'b0;
    logic              b_ready = 1'b1;
    logic [3:0]        b_tdata;
    logic              b_valid;
    logic              b_last;
    logic              b_user;
    logic              b_busy;
    logic              b_done;
    logic              b_blocked;
    logic [15:0]       b_stall;

    int   compared   = 0;
    int   mismatched = 0;
    pix_t exp_q[$];
    pix_t b_q[$];
    int   exp_stall   = 0;
    logic exp_blocked = 1'b0;
    int   last_data   = -1;

    int   lat;
    int   gaps;
    int   gap_after;

    axis_img_source #(
        .DATA_W     (DATA_W),
        .IMG_W      (IMG_W),
        .IMG_H      (IMG_H),
        .GAP_EVERY  (GAP_EVERY),
        .BLOCK_LIMIT(BLOCK_LIMIT)
    ) dut (
        .ap_clk       (ap_clk),
        .ap_rst_n     (ap_rst_n),
        .start        (start),
        .gap_en       (gap_en),
        .img_in_TDATA (img_in_TDATA),
        .img_in_TVALID(img_in_TVALID),
        .img_in_TREADY(img_in_TREADY),
        .img_in_TLAST (img_in_TLAST),
        .img_in_TUSER (img_in_TUSER),
        .busy         (busy),
        .done         (done),
        .blocked      (blocked),
        .stall_cnt    (stall_cnt)
    );

    axis_img_source #(
        .DATA_W     (4),
        .IMG_W      (8),
        .IMG_H      (4),
        .GAP_EVERY  (4),
        .BLOCK_LIMIT(64)
    ) dut_wrap (
        .ap_clk       (ap_clk),
        .ap_rst_n     (ap_rst_n),
        .start        (b_start),
        .gap_en       (b_gap),
        .img_in_TDATA (b_tdata),
        .img_in_TVALID(b_valid),
        .img_in_TREADY(b_ready),
        .img_in_TLAST (b_last),
        .img_in_TUSER (b_user),
        .busy         (b_busy),
        .done         (b_done),
        .blocked      (b_blocked),
        .stall_cnt    (b_stall)
    );

    // 10 time-unit clock; rising edges at 5, 15, 25 ...
    always #5 ap_clk = ~ap_clk;

    // Single comparison point: counts and reports every check.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Queue the beats of one 4x2 frame in raster order.
    task automatic pushFrame();
        pix_t p;
        for (int yy = 0; yy < IMG_H; yy++) begin
            for (int xx = 0; xx < IMG_W; xx++) begin
                p.data = 8'(yy * IMG_W + xx);
                p.last = (xx == IMG_W - 1);
                p.user = (xx == 0 && yy == 0);
                exp_q.push_back(p);
            end
        end
    endtask

    // Called once per cycle at the falling edge: drives TREADY for the
    // coming rising edge, checks the presented beat against the queue head
    // and checks stall_cnt/blocked against the reference model.
    task automatic checkOutput(input logic ready);
        logic next_blk;
        img_in_TREADY = ready;
        check("stall_cnt", stall_cnt, exp_stall);
        check("blocked", blocked, exp_blocked);
        if (img_in_TVALID) begin
            if (exp_q.size() == 0) begin
                check("tvalid_spurious", img_in_TVALID, 1'b0);
            end else begin
                check("tdata", img_in_TDATA, exp_q[0].data);
                check("tlast", img_in_TLAST, exp_q[0].last);
                check("tuser", img_in_TUSER, exp_q[0].user);
                if (ready) begin
                    last_data = exp_q[0].data;
                    void'(exp_q.pop_front());
                end
            end
        end
        next_blk = exp_blocked | (exp_stall >= BLOCK_LIMIT);
        if (img_in_TVALID) begin
            if (ready) exp_stall = 0;
            else if (exp_stall < 65535) exp_stall = exp_stall + 1;
        end
        exp_blocked = next_blk;
    endtask

    // Raise start for one cycle from idle and queue the expected frame.
    task automatic applyStimulus(input logic gap);
        @(negedge ap_clk);
        start  = 1'b1;
        gap_en = gap;
        checkOutput(1'b1);
        check("idle_busy", busy, 1'b0);
        exp_stall   = 0;
        exp_blocked = 1'b0;
        pushFrame();
    endtask

    // Run one frame. Latency counts the start cycle and the done cycle
    // inclusively. TREADY is held low for stall_len cycles while the pixel
    // stall_at is presented; start is pulsed again at cycle pulse_at.
    task automatic runFrame(input logic gap, input int stall_at, input int stall_len,
                            input int pulse_at, output int f_lat, output int f_gaps,
                            output int f_gap_after);
        int   cyc;
        int   stalled;
        bit   seen;
        logic rdy;
        f_lat       = 0;
        f_gaps      = 0;
        f_gap_after = -1;
        stalled     = 0;
        seen        = 1'b0;
        applyStimulus(gap);
        cyc = 1;
        while (!seen && cyc < 200) begin
            @(negedge ap_clk);
            start = (cyc == pulse_at);
            rdy   = 1'b1;
            if (img_in_TVALID && int'(img_in_TDATA) == stall_at && stalled < stall_len) begin
                rdy = 1'b0;
                stalled++;
            end
            checkOutput(rdy);
            if (busy && !img_in_TVALID && !done) begin
                f_gaps++;
                f_gap_after = last_data;
            end
            if (done) begin
                seen  = 1'b1;
                f_lat = cyc + 1;
            end
            cyc++;
        end
        start = 1'b0;
        check("frame_done_seen", done, 1'b1);
        check("frame_drained", exp_q.size(), 0);
    endtask

    initial begin
        bit found;
        int n;
        bit bseen;
        pix_t p;

        $display("[TB] reset checks");
        #1 ap_rst_n = 1'b0;
        #1;
        check("rst_tvalid", img_in_TVALID, 1'b0);
        check("rst_tdata", img_in_TDATA, 8'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_blocked", blocked, 1'b0);
        check("rst_stall_cnt", stall_cnt, 16'd0);
        repeat (2) @(negedge ap_clk);
        #2 ap_rst_n = 1'b1;

        $display("[TB] plain frame, mid-frame start ignored");
        runFrame(1'b0, -1, 0, 4, lat, gaps, gap_after);
        check("lat_plain", lat, 10);
        check("gaps_plain", gaps, 0);
        @(negedge ap_clk);
        checkOutput(1'b1);
        check("done_pulse_width", done, 1'b0);
        check("busy_after_done", busy, 1'b0);

        $display("[TB] frame with gap insertion");
        runFrame(1'b1, -1, 0, -1, lat, gaps, gap_after);
        check("lat_gap", lat, 11);
        check("gaps_count", gaps, 1);
        check("gap_after_pixel", gap_after, 3);

        $display("[TB] five-cycle stall on pixel 2");
        runFrame(1'b0, 2, 5, -1, lat, gaps, gap_after);
        check("lat_stall5", lat, 15);
        check("blocked_stall5", blocked, 1'b0);

        $display("[TB] twenty-cycle stall on pixel 2");
        runFrame(1'b0, 2, 20, -1, lat, gaps, gap_after);
        check("lat_stall20", lat, 30);
        check("blocked_after_frame", blocked, 1'b1);

        $display("[TB] next start clears blocked");
        runFrame(1'b0, -1, 0, -1, lat, gaps, gap_after);
        check("blocked_cleared", blocked, 1'b0);
        check("lat_after_block", lat, 10);

        $display("[TB] reset mid-frame at pixel 5");
        applyStimulus(1'b0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge ap_clk);
            start = 1'b0;
            checkOutput(1'b1);
            if (img_in_TVALID && img_in_TDATA == 8'd5) found = 1'b1;
        end
        check("reached_pixel5", found, 1'b1);
        #2 ap_rst_n = 1'b0;
        #1;
        check("mid_rst_tvalid", img_in_TVALID, 1'b0);
        check("mid_rst_tdata", img_in_TDATA, 8'd0);
        check("mid_rst_tlast", img_in_TLAST, 1'b0);
        check("mid_rst_tuser", img_in_TUSER, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_blocked", blocked, 1'b0);
        check("mid_rst_stall_cnt", stall_cnt, 16'd0);
        exp_q.delete();
        exp_stall   = 0;
        exp_blocked = 1'b0;
        @(negedge ap_clk);
        #2 ap_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge ap_clk);
            checkOutput(1'b1);
            check("no_done_after_reset", done, 1'b0);
            check("idle_after_reset", img_in_TVALID, 1'b0);
        end
        runFrame(1'b0, -1, 0, -1, lat, gaps, gap_after);
        check("lat_after_reset", lat, 10);

        $display("[TB] 4-bit pixels wrap on an 8x4 image");
        for (int i = 0; i < 32; i++) begin
            p.data = 8'(i % 16);
            p.last = (i % 8 == 7);
            p.user = (i == 0);
            b_q.push_back(p);
        end
        @(negedge ap_clk);
        b_start = 1'b1;
        n       = 0;
        bseen   = 1'b0;
        for (int c = 0; c < 100 && !bseen; c++) begin
            @(negedge ap_clk);
            b_start = 1'b0;
            if (b_valid) begin
                if (b_q.size() == 0) begin
                    check("b_tvalid_spurious", b_valid, 1'b0);
                end else begin
                    if (n == 16) check("b_wrap_at_16", b_tdata, 4'd0);
                    check("b_tdata", b_tdata, b_q[0].data);
                    check("b_tlast", b_last, b_q[0].last);
                    check("b_tuser", b_user, b_q[0].user);
                    void'(b_q.pop_front());
                    n++;
                end
            end
            if (b_done) bseen = 1'b1;
        end
        check("b_done_seen", b_done, 1'b1);
        check("b_beats", n, 32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/axis_img_source.md
AXIS_IMG_SOURCE -- requirements
Module: axis_img_source

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, the pixel/TDATA width in bits.
REQ-002 SHALL provide parameter IMG_W, default 16, the pixels per line.
REQ-003 SHALL provide parameter IMG_H, default 16, the lines per frame.
REQ-004 SHALL provide parameter GAP_EVERY, default 4, the transfers between inserted idle cycles.
REQ-005 SHALL provide parameter BLOCK_LIMIT, default 64, the consecutive stalled cycles before block is flagged.
REQ-006 SHALL have port ap_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-007 SHALL have port ap_rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port start, input, 1, a frame request, sampled in IDLE only.
REQ-009 SHALL have port gap_en, input, 1, which enables periodic idle-cycle insertion.
REQ-010 SHALL have port img_in_TDATA, output, DATA_W, the pixel data.
REQ-011 SHALL have port img_in_TVALID, output, 1, data valid.
REQ-012 SHALL have port img_in_TREADY, input, 1, the consumer ready signal.
REQ-013 SHALL have port img_in_TLAST, output, 1, marking the last pixel of each line.
REQ-014 SHALL have port img_in_TUSER, output, 1, marking the first pixel of the frame.
REQ-015 SHALL have port busy, output, 1, high while a frame is in progress.
REQ-016 SHALL have port done, output, 1, a one-cycle pulse after the final transfer.
REQ-017 SHALL have port blocked, output, 1, a sticky flag indicating that the stream stall limit was reached.
REQ-018 SHALL have port stall_cnt, output, 16, the current consecutive stall count.

Function
REQ-019 SHALL implement FSM states IDLE, SEND, GAP and DONE.
REQ-020 SHALL go IDLE->SEND on start=1, clearing the x/y counters, the transfer counter, stall_cnt and blocked.
REQ-021 SHALL drive TVALID=1 in SEND and TVALID=0 in IDLE, GAP and DONE.
REQ-022 SHALL define a transfer as a cycle with TVALID=1 and TREADY=1.
REQ-023 SHALL hold TDATA, TLAST and TUSER stable while TVALID=1 and TREADY=0, and SHALL NOT deassert TVALID without a transfer.
REQ-024 SHALL drive TDATA as the low DATA_W bits of (y*IMG_W + x), truncated with wrap-around and no saturation.
REQ-025 SHALL set TLAST=1 when x==IMG_W-1, and TUSER=1 when x==0 and y==0.
REQ-026 SHALL, on each transfer, increment x; when x==IMG_W-1, set x to 0 and increment y.
REQ-027 SHALL go SEND->DONE on a transfer with x==IMG_W-1 and y==IMG_H-1, with this check taking priority over a gap.
REQ-028 SHALL, when gap_en=1 and a transfer completes the GAP_EVERY-th transfer since the last gap, go SEND->GAP, reset the transfer counter, hold GAP for exactly 1 cycle, and then return to SEND.
REQ-029 SHALL, when gap_en=0, neither insert gaps nor advance the transfer counter.
REQ-030 SHALL sample gap_en per transfer; a change of gap_en mid-frame SHALL affect only subsequent transfers.
REQ-031 SHALL hold done=1 for exactly the DONE cycle and then return to IDLE.
REQ-032 SHALL hold busy=1 in SEND, GAP and DONE, and busy=0 in IDLE.
REQ-033 SHALL ignore start outside IDLE, with no restart and no counter disturbance.
REQ-034 SHALL increment stall_cnt, saturating at 16'hFFFF, in every cycle with TVALID=1 and TREADY=0, and SHALL clear it to 0 on a transfer.
REQ-035 SHALL keep stall_cnt unchanged in GAP, DONE and IDLE.
REQ-036 SHALL set blocked=1 on the cycle after stall_cnt reaches BLOCK_LIMIT, and SHALL hold it until the next accepted start or reset.
REQ-037 SHALL NOT abort the frame when blocked is set; transmission continues once TREADY returns.
REQ-038 SHALL produce a minimum frame latency, from start to done, of IMG_W*IMG_H+2 cycles when TREADY is held at 1 and gap_en=0.

Reset
REQ-039 SHALL, on ap_rst_n=0, immediately and asynchronously force state IDLE, TVALID=0, TDATA=0, TLAST=0, TUSER=0, busy=0, done=0, blocked=0, stall_cnt=0, and zero the x, y and transfer counters.
REQ-040 SHALL discard any partial frame on reset mid-frame, and SHALL NOT emit a done for that frame.
REQ-041 SHALL treat reset release as synchronous to ap_clk, with the first start accepted on the first rising edge after ap_rst_n=1.

Verification
REQ-042 Verification SHALL cover IMG_W=4, IMG_H=2, TREADY=1, gap_en=0 -> TDATA 0..7 with TUSER on 0, TLAST on 3 and 7, done 10 cycles after start.
REQ-043 Verification SHALL cover the same configuration with gap_en=1 and GAP_EVERY=4 -> one TVALID=0 cycle after TDATA=3 and none after TDATA=7, with done 11 cycles after start.
REQ-044 Verification SHALL cover TREADY=0 for 5 cycles during TDATA=2 -> TDATA, TLAST and TUSER stable, stall_cnt ramping 1..5 and then 0 on the transfer.
REQ-045 Verification SHALL cover BLOCK_LIMIT=8 with TREADY held at 0 for 20 cycles -> blocked=1 from the cycle after stall_cnt=8, still 1 after the frame completes, and cleared by the next start.
REQ-046 Verification SHALL cover ap_rst_n pulsed low mid-frame at TDATA=5 -> all outputs 0 with no clock edge required, no done, and the next start restarting at TDATA=0 with TUSER=1.
REQ-047 Verification SHALL cover DATA_W=4, IMG_W=8, IMG_H=4 -> TDATA wrapping 15->0 at pixel 16.
